// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int MAX_W     = 64;

  // Quotient reported for a zero divisor; truncated to the instance width.
  localparam logic [MAX_W-1:0] DBZ_QUO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic        [WIDTH:0] shifted;
  logic signed [WIDTH:0] diff;

  // rem < dvs holds between steps, so bit WIDTH of the difference is its true sign.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    diff     = signed'(shifted) - signed'({1'b0, dvs});
    rem_next = (diff < 0) ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], ~diff[WIDTH]};
  end

endmodule

// File: rtl/div32_seq.sv
// Sequential signed/unsigned divider: one quotient bit per cycle, fixed latency.
module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dvs_r;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             q_neg, r_neg, dbz_r;
  logic             accept;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic en);
    return (en && (v < 0)) ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? WIDTH'(-v) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .dvs      (dvs_r),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rem_r <= '0;
      quo_r <= '0;
      dvs_r <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dbz_r <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (divisor == '0) begin
              quo_r <= WIDTH'(DBZ_QUO);
              rem_r <= dividend;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
              dbz_r <= 1'b1;
            end else begin
              quo_r <= mag(dividend, is_signed);
              rem_r <= '0;
              dvs_r <= mag(divisor, is_signed);
              q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg <= is_signed & dividend[WIDTH-1];
              dbz_r <= 1'b0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          // Signs are folded into the final step so DONE presents finished results.
          if (cnt == LAST) begin
            quo_r <= apply_sign(quo_step, q_neg);
            rem_r <= apply_sign(rem_step, r_neg);
          end else begin
            quo_r <= quo_step;
            rem_r <= rem_step;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quo_r;
  assign remainder   = rem_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div32_seq.sv
// Directed and random checks of div32_seq against a queue of expected results.
module tb_div32_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         is_signed = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  div32_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    return e;
  endfunction

  // Reference built on the simulator's own division operators.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [W-1:0] sa, sb2;
    exp_t e;
    sa = a;
    sb2 = b;
    if (b == '0) e = mk('1, a, 1'b1);
    else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) e = mk(32'h8000_0000, '0, 1'b0);
    else if (s) e = mk(W'(sa / sb2), W'(sa % sb2), 1'b0);
    else e = mk(a / b, a % b, 1'b0);
    return e;
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input exp_t e, input int exp_lat, input int hold, input string tag);
    exp_t g;
    int   lat;
    accept(a, b, s, tag);
    sb.push_back(e);
    check({tag, "_busy"}, W'(in_ready), W'(0));
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, W'(lat), W'(exp_lat));
    g = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      check({tag, "_quo"}, quotient, g.q);
      check({tag, "_rem"}, remainder, g.r);
      check({tag, "_dbz"}, W'(div_by_zero), W'(g.z));
      check({tag, "_valid"}, W'(out_valid), W'(1));
      check({tag, "_no_accept"}, W'(in_ready), W'(0));
      if (i < hold) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle_ready"}, W'(in_ready), W'(1));
    check({tag, "_idle_valid"}, W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;

    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_quo", quotient, '0);
    check("rst_rem", remainder, '0);
    check("rst_dbz", W'(div_by_zero), W'(0));
    #12 rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0), 33, 5, "u100_7");
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0), 33, 0, "s_m7_2");
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, mk(32'hFFFF_FFFD, 32'd1, 1'b0), 33, 0, "s_7_m2");
    run_op(32'd5, 32'd0, 1'b0, mk(32'hFFFF_FFFF, 32'd5, 1'b1), 1, 2, "u5_0");
    run_op(32'd5, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'd5, 1'b1), 1, 0, "s5_0");
    run_op(32'hFFFF_FFF9, 32'd0, 1'b1, mk(32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1), 1, 0, "s_m7_0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, mk(32'h8000_0000, 32'd0, 1'b0), 33, 0, "s_ovf");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, mk(32'd0, 32'h8000_0000, 1'b0), 33, 0, "u_big");
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, mk(32'hFFFF_FFFF, 32'd0, 1'b0), 33, 0, "u_max_1");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, mk(32'd1, 32'd0, 1'b0), 33, 0, "s_m1_m1");

    // Abort an operation ten cycles into CALC.
    accept(32'd1000, 32'd3, 1'b0, "abort");
    repeat (9) begin
      @(posedge clk); #1;
    end
    check("abort_pre_valid", W'(out_valid), W'(0));
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_quo", quotient, '0);
    check("abort_rem", remainder, '0);
    check("abort_dbz", W'(div_by_zero), W'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("abort_post_valid", W'(out_valid), W'(0));
    run_op(32'd9, 32'd3, 1'b0, mk(32'd3, 32'd0, 1'b0), 33, 0, "after_rst_9_3");

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      rs = (i % 2) == 1;
      run_op(ra, rb, rs, model(ra, rb, rs), (rb == '0) ? 1 : 33, i % 3, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
